// File: rtl/hmac_stream_arbiter_if.sv
// AXI-Stream style bundle shared by every request, engine and result port of the HMAC arbiter.
interface hmac_stream_arbiter_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 6
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [ID_WIDTH-1:0]     tid;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tlast, output tready);
endinterface

// File: rtl/hmac_stream_arbiter.sv
// Two-requester round-robin arbiter in front of a shared in-order HMAC engine; a tag FIFO
// remembers which requester owns each in-flight packet so results are steered back to it.
module hmac_stream_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 6,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    hmac_stream_arbiter_if.slave       s0_axis,
    hmac_stream_arbiter_if.slave       s1_axis,
    hmac_stream_arbiter_if.master      m_eng,
    hmac_stream_arbiter_if.slave       s_eng,
    hmac_stream_arbiter_if.master      m0_axis,
    hmac_stream_arbiter_if.master      m1_axis,
    output logic [$clog2(TAG_DEPTH):0] outstanding
);
    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    state_e               state_q, state_d;
    logic                 rrPtr_q, rrPtr_d;
    logic                 sopPending_q, sopPending_d;
    logic [TAG_DEPTH-1:0] tagMem_q, tagMem_d;
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                  reqValid, reqLast;
    logic [DATA_WIDTH-1:0] reqData;
    logic [KEEP_W-1:0]     reqKeep;
    logic [ID_WIDTH-1:0]   reqId;
    logic                  s0Ready, s1Ready;
    logic                  engHs, push, pop, full, empty, headTag, resLive;

    // Request mux; reset forces every handshake signal low even before the state settles.
    always_comb begin
        reqValid = 1'b0;
        reqData  = s0_axis.tdata;
        reqKeep  = s0_axis.tkeep;
        reqId    = s0_axis.tid;
        reqLast  = s0_axis.tlast;
        s0Ready  = 1'b0;
        s1Ready  = 1'b0;
        unique case (state_q)
            GRANT0: begin
                reqValid = s0_axis.tvalid;
                s0Ready  = m_eng.tready;
            end
            GRANT1: begin
                reqValid = s1_axis.tvalid;
                reqData  = s1_axis.tdata;
                reqKeep  = s1_axis.tkeep;
                reqId    = s1_axis.tid;
                reqLast  = s1_axis.tlast;
                s1Ready  = m_eng.tready;
            end
            default: ;
        endcase
        if (areset) begin
            reqValid = 1'b0;
            s0Ready  = 1'b0;
            s1Ready  = 1'b0;
        end
    end

    assign m_eng.tvalid   = reqValid;
    assign m_eng.tdata    = reqData;
    assign m_eng.tkeep    = reqKeep;
    assign m_eng.tid      = reqId;
    assign m_eng.tlast    = reqLast;
    assign s0_axis.tready = s0Ready;
    assign s1_axis.tready = s1Ready;

    assign engHs   = reqValid && m_eng.tready;
    assign push    = engHs && sopPending_q;
    assign full    = (count_q == CNT_W'(TAG_DEPTH));
    assign empty   = (count_q == '0);
    assign headTag = tagMem_q[rdPtr_q];
    assign resLive = !empty && !areset;

    // Results follow the head tag; the non-selected output sees data but never tvalid.
    assign s_eng.tready   = resLive && (headTag ? m1_axis.tready : m0_axis.tready);
    assign m0_axis.tvalid = resLive && !headTag && s_eng.tvalid;
    assign m1_axis.tvalid = resLive && headTag && s_eng.tvalid;
    assign m0_axis.tdata  = s_eng.tdata;
    assign m0_axis.tkeep  = s_eng.tkeep;
    assign m0_axis.tid    = s_eng.tid;
    assign m0_axis.tlast  = s_eng.tlast;
    assign m1_axis.tdata  = s_eng.tdata;
    assign m1_axis.tkeep  = s_eng.tkeep;
    assign m1_axis.tid    = s_eng.tid;
    assign m1_axis.tlast  = s_eng.tlast;
    assign pop            = s_eng.tvalid && s_eng.tready && s_eng.tlast;
    assign outstanding    = count_q;

    always_comb begin
        state_d      = state_q;
        rrPtr_d      = rrPtr_q;
        sopPending_d = sopPending_q;
        tagMem_d     = tagMem_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        unique case (state_q)
            IDLE: begin
                if (!full) begin
                    if (s0_axis.tvalid && s1_axis.tvalid) state_d = rrPtr_q ? GRANT0 : GRANT1;
                    else if (s0_axis.tvalid)              state_d = GRANT0;
                    else if (s1_axis.tvalid)              state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (engHs && reqLast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (engHs) sopPending_d = reqLast;
        if (push) begin
            tagMem_d[wrPtr_q] = (state_q == GRANT1);
            wrPtr_d           = wrPtr_q + 1'b1;
            rrPtr_d           = (state_q == GRANT1);
        end
        if (pop) rdPtr_d = rdPtr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            rrPtr_q      <= 1'b1;
            sopPending_q <= 1'b1;
            tagMem_q     <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rrPtr_q      <= rrPtr_d;
            sopPending_q <= sopPending_d;
            tagMem_q     <= tagMem_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: doc/hmac_stream_arbiter.md
HMAC_STREAM_ARBITER -- requirements
Module: hmac_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 512: tdata width of every stream; tkeep width is DATA_WIDTH/8.
REQ-002 Parameter ID_WIDTH, default 6: tid width of every stream.
REQ-003 Parameter TAG_DEPTH, default 8, power of two: maximum number of packets in flight inside the engine.
REQ-004 Port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port areset, input, 1: synchronous, active-high reset.
REQ-006 Port bundle s0_axis_t{valid,data,keep,id,last}, input, 1/DW/DW/8/ID/1: requester 0 packet stream.
REQ-007 Port s0_axis_tready, output, 1: requester 0 backpressure.
REQ-008 Port bundle s1_axis_t{valid,data,keep,id,last} with s1_axis_tready: requester 1 packet stream, same widths and directions as s0.
REQ-009 Port bundle m_eng_t{valid,data,keep,id,last}, output, with m_eng_tready input: packet stream to the shared HMAC engine.
REQ-010 Port bundle s_eng_t{valid,data,keep,id,last}, input, with s_eng_tready output: result stream from the engine.
REQ-011 Port bundles m0_axis_t* and m1_axis_t*, output, with tready input: per-requester result streams.
REQ-012 Port outstanding, output, $clog2(TAG_DEPTH)+1: number of packets granted and not yet returned.

Function
REQ-013 The block SHALL assume the engine returns exactly one result packet, ending in a tlast beat, per input packet, in input order.
REQ-014 The arbiter FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-015 In IDLE with tag FIFO not full: only s0 valid -> GRANT0; only s1 valid -> GRANT1; both valid -> the requester not served last (rr pointer).
REQ-016 In IDLE with tag FIFO full, the FSM SHALL stay in IDLE regardless of requests.
REQ-017 In GRANTx, m_eng_t* SHALL equal sx_axis_t* combinationally; sx_axis_tready = m_eng_tready; the other requester's tready SHALL be 0.
REQ-018 In IDLE, both s*_axis_tready and m_eng_tvalid SHALL be 0.
REQ-019 The first handshaked beat of a granted packet SHALL push tag x into the tag FIFO and set rr pointer to x.
REQ-020 A handshaked beat with tlast=1 in GRANTx SHALL return the FSM to IDLE, giving exactly one bubble cycle between packets.
REQ-021 The grant SHALL NOT change mid-packet, even if the other requester is valid.
REQ-022 When the tag FIFO is empty, s_eng_tready SHALL be 0 and m0/m1 tvalid SHALL be 0.
REQ-023 When not empty, the head tag h SHALL route s_eng_t* to mh_axis_t* combinationally, with s_eng_tready = mh_axis_tready; the other output's tvalid SHALL be 0.
REQ-024 A handshaked result beat with tlast=1 SHALL pop the head tag.
REQ-025 A push and a pop in the same cycle SHALL leave outstanding unchanged; otherwise push increments it and pop decrements it.
REQ-026 tdata, tkeep, tid and tlast SHALL pass unmodified in both directions; added latency is zero cycles.
REQ-027 Tag FIFO read and write pointers SHALL wrap modulo TAG_DEPTH; full is outstanding==TAG_DEPTH.

Reset
REQ-028 On areset=1 at a clock edge: FSM to IDLE, rr pointer to 1 (s0 preferred first), tag FIFO emptied, outstanding to 0.
REQ-029 During and after reset, all tvalid and tready outputs SHALL be 0 until the state rules above apply.
REQ-030 Reset mid-packet SHALL abandon the packet with no tag retained; the engine shares areset.

Verification
REQ-031 After reset, s0 and s1 both valid with 2-beat packets -> s0 packet first, 1 bubble cycle, then s1; outstanding reaches 2.
REQ-032 s1 is mid-packet and s0 goes valid -> s1 tready stays 1 until its tlast, and s0 tready stays 0 until then.
REQ-033 Eight 1-beat s0 packets with the engine stalled (m_eng accepts, s_eng_tvalid=0) -> outstanding=8 and no ninth grant; one result tlast frees a slot, and a grant follows the next cycle.
REQ-034 Interleaved tags 0,1,0 queued; results returned -> they appear on m0, m1, m0 in order, with tdata/tid bit-exact.
REQ-035 m1_axis_tready=0 while the head tag is 1 -> s_eng_tready=0 and the result is held with no loss; m0 is not served.
REQ-036 Push and pop in the same cycle at outstanding=3 -> outstanding stays 3; areset mid-packet -> outstanding=0 and all tvalid=0 next cycle.
